char_row_serializer: RTL and testbench

CHAR_ROW_SERIALIZER -- requirements
Module: char_row_serializer

---
 rtl/trs_video_pkg.sv | 42 ++++
 rtl/char_row_serializer_glyph_fifo.sv | 71 +++++++
 rtl/char_row_serializer.sv | 159 +++++++++++++++
 tb/tb_char_row_serializer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/trs_video_pkg.sv
// Shared constants, tag type and helpers for the character-row video path.
package trs_video_pkg;

  localparam int unsigned GLYPH_W     = 6;
  localparam int unsigned GLYPH_ROWS  = 12;
  localparam int unsigned ROM_AW      = 10;
  localparam int unsigned ROM_LATENCY = 2;

  // Last glyph row that carries text pixels; rows beyond it render blank.
  localparam logic [3:0] TEXT_LAST_ROW = 4'd7;

  // Graphics block row groups: top, middle, bottom (inclusive last rows).
  localparam logic [3:0] GFX_TOP_LAST = 4'd3;
  localparam logic [3:0] GFX_MID_LAST = 4'd7;
  localparam logic [3:0] GFX_BOT_LAST = 4'(GLYPH_ROWS - 1);

  typedef logic [GLYPH_W-1:0] glyph_row_t;

  // Sideband travelling alongside the ROM read.
  typedef struct packed {
    logic       valid;
    logic       blank;
    logic       gfx;
    logic [1:0] gfx_bits;  // [0] = left half lit, [1] = right half lit
  } row_tag_t;

  // Select the left/right block bits for the row group containing 'row'.
  function automatic logic [1:0] gfx_pair(input logic [5:0] code, input logic [3:0] row);
    if (row <= GFX_TOP_LAST) begin
      return code[1:0];
    end else if (row <= GFX_MID_LAST) begin
      return code[3:2];
    end
    return code[5:4];
  endfunction

  // Expand a left/right pair into a 6-pixel row (left = pixels 5..3).
  function automatic glyph_row_t gfx_row(input logic [1:0] bits);
    return {{3{bits[0]}}, {3{bits[1]}}};
  endfunction

endpackage

// File: rtl/char_row_serializer_glyph_fifo.sv
// glyph_fifo: small circular buffer of glyph-row results with full/empty/count.
module glyph_fifo
  import trs_video_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = GLYPH_W,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer/count state; reset empties the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only observed through count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/char_row_serializer.sv
// char_row_serializer: accepts character-row requests, reads the font ROM
// with fixed latency, buffers glyph rows and shifts them out one pixel per
// pix_ce. Optional macro GRAPHICS_CHARS_EN enables 2x3 block graphics for
// codes 0x80..0xBF; without it req_char[7] is ignored.
module char_row_serializer
  import trs_video_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_char,
  input  logic [3:0]  req_row,
  output logic [9:0]  rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  input  logic [5:0]  rom_dout,
  input  logic        pix_ce,
  output logic        pixel,
  output logic        pixel_valid,
  output logic        underrun
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);
  localparam int unsigned LEFT_W  = $clog2(GLYPH_W + 1);
  localparam int unsigned LAST_ST = ROM_LATENCY - 1;

  logic             run_q;
  logic             accept;
  logic             is_gfx;
  row_tag_t         req_tag;
  row_tag_t         tag_q [ROM_LATENCY];
  logic [OCC_W-1:0] occupancy;

  logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
  glyph_row_t       fifo_wdata, fifo_head;
  logic [CNT_W-1:0] fifo_count;

  glyph_row_t       shift_q, shift_d;
  logic [LEFT_W-1:0] left_q, left_d;

`ifdef GRAPHICS_CHARS_EN
  assign is_gfx = (req_char[7:6] == 2'b10);
`else
  logic unused_code_msb;
  assign is_gfx          = 1'b0;
  assign unused_code_msb = req_char[7];
`endif

  assign req_ready = run_q && (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rom_ad    = {req_char[6:0], req_row[2:0]};
  assign rom_ce    = accept;
  assign rom_oce   = 1'b1;

  // Goes high on the first edge after reset releases, opening the request port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Classify the incoming request; blank rows still occupy a pipeline slot.
  always_comb begin
    req_tag          = '0;
    req_tag.valid    = accept;
    req_tag.gfx      = is_gfx;
    req_tag.gfx_bits = gfx_pair(req_char[5:0], req_row);
    req_tag.blank    = (req_row > GFX_BOT_LAST) || (!is_gfx && (req_row > TEXT_LAST_ROW));
  end

  // Tag pipeline matching the ROM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= req_tag;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Requests in flight plus buffered rows bound the request port.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
      occupancy = occupancy + OCC_W'(tag_q[i].valid);
    end
  end

  // Choose the row written into the buffer when the ROM result lands.
  always_comb begin
    fifo_wdata = rom_dout;
    if (tag_q[LAST_ST].blank) begin
      fifo_wdata = '0;
    end else if (tag_q[LAST_ST].gfx) begin
      fifo_wdata = gfx_row(tag_q[LAST_ST].gfx_bits);
    end
  end

  assign fifo_wr = tag_q[LAST_ST].valid && !fifo_full;

  glyph_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (GLYPH_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (reset),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign pixel_valid = (left_q != '0);
  assign pixel       = pixel_valid && shift_q[GLYPH_W-1];
  assign underrun    = run_q && pix_ce && !pixel_valid;

  // Shifter: advance on pix_ce; reload when idle or on the last pixel so
  // consecutive rows stay gapless.
  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    fifo_rd = 1'b0;
    if (pix_ce && pixel_valid) begin
      shift_d = {shift_q[GLYPH_W-2:0], 1'b0};
      left_d  = left_q - LEFT_W'(1);
    end
    if ((!pixel_valid || (pix_ce && (left_q == LEFT_W'(1)))) && !fifo_empty) begin
      shift_d = fifo_head;
      left_d  = LEFT_W'(GLYPH_W);
      fifo_rd = 1'b1;
    end
  end

  // Shifter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      left_q  <= '0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
    end
  end

endmodule

// File: tb/tb_char_row_serializer.sv
// Directed bench for char_row_serializer with a 2-cycle registered font ROM model.
module tb_char_row_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_char = '0;
  logic [3:0] req_row = '0;
  logic [9:0] rom_ad;
  logic       rom_ce, rom_oce;
  logic [5:0] rom_dout = '0;
  logic       pix_ce = 1'b0;
  logic       pixel, pixel_valid, underrun;

  int unsigned vec_cnt  = 0;
  int unsigned miss_cnt = 0;
  logic [9:0]  rom_addr_q = '0;

  always #5 clk = ~clk;

  char_row_serializer #(.FIFO_DEPTH(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_char    (req_char),
    .req_row     (req_row),
    .rom_ad      (rom_ad),
    .rom_ce      (rom_ce),
    .rom_oce     (rom_oce),
    .rom_dout    (rom_dout),
    .pix_ce      (pix_ce),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .underrun    (underrun)
  );

  // Font ROM contents: one fixed glyph row, everything else a simple hash.
  function automatic logic [5:0] rom_f(input logic [9:0] a);
    if (a == 10'h208) return 6'h04;
    return a[5:0] ^ a[9:4];
  endfunction

  // Address register on rom_ce, output register on rom_oce.
  always @(posedge clk) begin
    if (rom_ce) rom_addr_q <= rom_ad;
    if (rom_oce) rom_dout <= rom_f(rom_addr_q);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ch, input logic [3:0] row);
    int unsigned guard = 0;
    req_char  = ch;
    req_row   = row;
    req_valid = 1'b1;
    #1;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!req_ready) check_eq("send_timeout", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic get_row(input string tag, input logic [5:0] exp, input bit gapless);
    int unsigned guard = 0;
    logic [5:0]  r = '0;
    logic        vld_all = 1'b1;
    if (gapless) check_eq({tag, "_gapless"}, pixel_valid, 1);
    while (!pixel_valid && guard < 50) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 6; i++) begin
      r[5-i]  = pixel;
      vld_all = vld_all & pixel_valid;
      pix_ce  = 1'b1;
      tick();
      pix_ce  = 1'b0;
    end
    check_eq({tag, "_valid"}, vld_all, 1);
    check_eq(tag, r, exp);
  endtask

  task automatic latency_row(input string tag, input logic [7:0] ch, input logic [3:0] row,
                             input logic [5:0] exp);
    int unsigned lat = 0;
    send(ch, row);
    while (!pixel_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 3);
    get_row(tag, exp, 0);
    check_eq({tag, "_drop"}, pixel_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with pix_ce high to show underrun stays quiet in reset.
    pix_ce = 1'b1;
    tick();
    tick();
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_pixel", pixel, 0);
    check_eq("rst_pixel_valid", pixel_valid, 0);
    check_eq("rst_underrun", underrun, 0);
    pix_ce = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("ready_after_rst", req_ready, 1);

    // Basic text row and address formation.
    req_char = 8'h41; req_row = 4'd0; req_valid = 1'b1;
    #1;
    check_eq("rom_ad_41_0", rom_ad, 10'h208);
    check_eq("rom_ce", rom_ce, 1);
    check_eq("rom_oce", rom_oce, 1);
    latency_row("t41r0", 8'h41, 4'd0, 6'b000100);
    latency_row("t41r9", 8'h41, 4'd9, 6'b000000);
    latency_row("t41r4", 8'h41, 4'd4, 6'h2C);
    latency_row("t41r12", 8'h41, 4'd12, 6'h00);

    // High codes: graphics blocks when enabled, text with bit 7 dropped otherwise.
    req_char = 8'h85; req_row = 4'd0; req_valid = 1'b1;
    #1;
    check_eq("rom_ad_85_0", rom_ad, 10'h028);
    req_valid = 1'b0;
`ifdef GRAPHICS_CHARS_EN
    latency_row("c85r0", 8'h85, 4'd0, 6'b111000);
    latency_row("c85r5", 8'h85, 4'd5, 6'b111000);
    latency_row("c85r9", 8'h85, 4'd9, 6'b000000);
    latency_row("cB1r1", 8'hB1, 4'd1, 6'b111000);
    latency_row("cB1r9", 8'hB1, 4'd9, 6'b111111);
    latency_row("cB1r13", 8'hB1, 4'd13, 6'b000000);
`else
    latency_row("c85r0", 8'h85, 4'd0, 6'h2A);
    latency_row("c85r5", 8'h85, 4'd5, 6'h2F);
    latency_row("c85r9", 8'h85, 4'd9, 6'h00);
    latency_row("cB1r1", 8'hB1, 4'd1, 6'h11);
    latency_row("cB1r9", 8'hB1, 4'd9, 6'h00);
    latency_row("cB1r13", 8'hB1, 4'd13, 6'h00);
`endif
    latency_row("cC1r0", 8'hC1, 4'd0, 6'h04);

    // Back-to-back requests with no pixel clock: flow control and gapless output.
    send(8'h41, 4'd1);
    send(8'h42, 4'd2);
    send(8'h43, 4'd3);
    check_eq("full_after_3", req_ready, 0);
    send(8'h30, 4'd7);
    tick(); tick(); tick();
    check_eq("full_hold", req_ready, 0);
    get_row("bb0", 6'h29, 0);
    check_eq("ready_after_drain", req_ready, 1);
    get_row("bb1", 6'h33, 1);
    get_row("bb2", 6'h3A, 1);
    get_row("bb3", 6'h1F, 1);
    check_eq("bb_empty", pixel_valid, 0);

    // Starved shifter.
    for (int i = 0; i < 4; i++) begin
      pix_ce = 1'b1;
      #1;
      check_eq("underrun_on", underrun, 1);
      check_eq("underrun_pixel", pixel, 0);
      tick();
    end
    pix_ce = 1'b0;
    #1;
    check_eq("underrun_off", underrun, 0);

    // Reset in the middle of a row with two rows buffered.
    send(8'h41, 4'd1);
    send(8'h42, 4'd2);
    send(8'h43, 4'd3);
    tick(); tick(); tick();
    pix_ce = 1'b1;
    tick(); tick();
    check_eq("pre_rst_valid", pixel_valid, 1);
    reset = 1'b1;
    #1;
    check_eq("midrst_pixel_valid", pixel_valid, 0);
    check_eq("midrst_pixel", pixel, 0);
    check_eq("midrst_ready", req_ready, 0);
    check_eq("midrst_underrun", underrun, 0);
    tick(); tick();
    reset  = 1'b0;
    pix_ce = 1'b0;
    tick();
    check_eq("ready_after_rst2", req_ready, 1);
    tick(); tick(); tick();
    check_eq("no_stale_row", pixel_valid, 0);
    send(8'h30, 4'd7);
    get_row("post_rst", 6'h1F, 0);
    check_eq("post_rst_empty", pixel_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
